pipe_hazard_ctrl: RTL and testbench

Central stall/flush/forwarding controller for the five-stage in-order RISC-V pipeline. It watches register addresses and control bits at the decode, execute, memory and writeback stages, the branch resolution in execute, and the data-memory handshake. From these it drives the hold, bubble and flush controls of the F/D, D/E and E/M pipeline latches and the execute-operand forwarding selects. It also keeps saturating performance counters of lost cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline control types: forwarding selects, hazard FSM states, x0 constant.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EM = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_MWAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A used source matches a producer's destination; x0 never matches.
    function automatic logic src_hit(input logic use_src, input logic [4:0] rs, input logic [4:0] rd);
        return use_src && (rd != REG_X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear, async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with lost-cycle counters.
// Build option: HAZARD_FWD_EN enables E/M and W forwarding; otherwise RAW hazards stall.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rs1,
    input  logic [4:0]       e_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_rf_we,
    input  logic             e_mem2rf,
    input  logic [4:0]       m_rd,
    input  logic             m_rf_we,
    input  logic [4:0]       w_rd,
    input  logic             w_rf_we,
    input  logic             e_br_taken,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             fd_hold,
    output logic             fd_flush,
    output logic             de_hold,
    output logic             de_bubble,
    output logic             em_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_mwait,
    output logic [CNT_W-1:0] perf_flush
);

    hz_state_t state_q, state_d;
    logic      hit_e, load_use, raw_stall;
    logic      freeze, flush, stall;
    fwd_sel_t  fwd_a_sel, fwd_b_sel;

    assign hit_e    = src_hit(d_use_rs1, d_rs1, e_rd) || src_hit(d_use_rs2, d_rs2, e_rd);
    assign load_use = e_rf_we && e_mem2rf && hit_e;

`ifdef HAZARD_FWD_EN
    function automatic fwd_sel_t fwd_pick(input logic [4:0] rs);
        if (m_rf_we && (m_rd != REG_X0) && (m_rd == rs))
            return FWD_EM;
        else if (w_rf_we && (w_rd != REG_X0) && (w_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign raw_stall = load_use;
    assign fwd_a_sel = fwd_pick(e_rs1);
    assign fwd_b_sel = fwd_pick(e_rs2);
`else
    logic hit_m;
    logic unused_fwd_srcs;

    // Without bypass paths any in-flight producer in E or M must drain first.
    assign hit_m     = src_hit(d_use_rs1, d_rs1, m_rd) || src_hit(d_use_rs2, d_rs2, m_rd);
    assign raw_stall = load_use || (e_rf_we && hit_e) || (m_rf_we && hit_m);
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
    assign unused_fwd_srcs = ^{e_rs1, e_rs2, w_rd, w_rf_we};
`endif

    // The entering cycle freezes too, so a ready N cycles late costs N+1 cycles.
    assign freeze = (state_q == HZ_MWAIT) || (m_mem_req && !m_mem_ready);
    assign flush  = e_br_taken && !freeze;
    assign stall  = raw_stall && !freeze && !e_br_taken;

    always_comb begin
        fd_hold   = 1'b0;
        fd_flush  = 1'b0;
        de_hold   = 1'b0;
        de_bubble = 1'b0;
        em_hold   = 1'b0;
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
        if (rst_n) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (freeze) begin
                fd_hold = 1'b1;
                de_hold = 1'b1;
                em_hold = 1'b1;
            end else if (flush) begin
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end else if (stall) begin
                fd_hold   = 1'b1;
                de_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN:   if (m_mem_req && !m_mem_ready) state_d = HZ_MWAIT;
            HZ_MWAIT: if (m_mem_ready)               state_d = HZ_RUN;
            default:                                 state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= HZ_RUN;
        else
            state_q <= state_d;
    end

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall),
        .clear_i (1'b0),
        .cnt_o   (perf_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mwait (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (freeze),
        .clear_i (1'b0),
        .cnt_o   (perf_mwait)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush),
        .clear_i (1'b0),
        .cnt_o   (perf_flush)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles vs a reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;
`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif
    // Control vector order: {fd_hold, fd_flush, de_hold, de_bubble, em_hold}
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_FREEZE = 5'b10101;
    localparam logic [4:0] C_FLUSH  = 5'b01010;
    localparam logic [4:0] C_STALL  = 5'b10010;

    logic          clk, rst_n;
    logic [4:0]    d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic          d_use_rs1, d_use_rs2, e_rf_we, e_mem2rf, m_rf_we, w_rf_we;
    logic          e_br_taken, m_mem_req, m_mem_ready;
    logic          fd_hold, fd_flush, de_hold, de_bubble, em_hold;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] perf_stall, perf_mwait, perf_flush;
    logic [4:0]    ctrl;

    int tests_run    = 0;
    int tests_failed = 0;

    bit mdl_wait;
    int mdl_stall, mdl_mwait, mdl_flush;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_rf_we(e_rf_we), .e_mem2rf(e_mem2rf),
        .m_rd(m_rd), .m_rf_we(m_rf_we), .w_rd(w_rd), .w_rf_we(w_rf_we),
        .e_br_taken(e_br_taken), .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
        .fd_hold(fd_hold), .fd_flush(fd_flush), .de_hold(de_hold), .de_bubble(de_bubble),
        .em_hold(em_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .perf_stall(perf_stall), .perf_mwait(perf_mwait), .perf_flush(perf_flush)
    );

    assign ctrl = {fd_hold, fd_flush, de_hold, de_bubble, em_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit reads(input logic u, input logic [4:0] rs, input logic [4:0] rd);
        return u && (rd != 5'd0) && (rs == rd);
    endfunction

    // 0 = normal, 1 = memory freeze, 2 = branch flush, 3 = data-hazard stall
    function automatic int classify();
        bit dep_e, dep_m;
        dep_e = reads(d_use_rs1, d_rs1, e_rd) || reads(d_use_rs2, d_rs2, e_rd);
        dep_m = reads(d_use_rs1, d_rs1, m_rd) || reads(d_use_rs2, d_rs2, m_rd);
        if (mdl_wait || (m_mem_req && !m_mem_ready)) return 1;
        if (e_br_taken) return 2;
        if (e_rf_we && e_mem2rf && dep_e) return 3;
        if (!FWD_ON && ((e_rf_we && dep_e) || (m_rf_we && dep_m))) return 3;
        return 0;
    endfunction

    function automatic logic [4:0] ctrl_of(input int c);
        case (c)
            1:       return C_FREEZE;
            2:       return C_FLUSH;
            3:       return C_STALL;
            default: return C_NONE;
        endcase
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (!FWD_ON) return 2'b00;
        if (m_rf_we && m_rd != 5'd0 && m_rd == rs) return 2'b01;
        if (w_rf_we && w_rd != 5'd0 && w_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_wait  <= 1'b0;
            mdl_stall <= 0;
            mdl_mwait <= 0;
            mdl_flush <= 0;
        end else begin
            if (classify() == 1 && mdl_mwait < CMAX) mdl_mwait <= mdl_mwait + 1;
            if (classify() == 2 && mdl_flush < CMAX) mdl_flush <= mdl_flush + 1;
            if (classify() == 3 && mdl_stall < CMAX) mdl_stall <= mdl_stall + 1;
            mdl_wait <= mdl_wait ? !m_mem_ready : (m_mem_req && !m_mem_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        d_rs1 = '0; d_rs2 = '0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_rf_we = 1'b0; e_mem2rf = 1'b0;
        m_rd = '0; m_rf_we = 1'b0; w_rd = '0; w_rf_we = 1'b0;
        e_br_taken = 1'b0; m_mem_req = 1'b0; m_mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        m_rd = 5'd5; m_rf_we = 1'b1; e_rs1 = 5'd5; e_br_taken = 1'b1; m_mem_req = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin tests_failed++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE); end
        tests_run++;
        if (fwd_a !== 2'b00) begin tests_failed++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
        tests_run++;
        if ({perf_stall, perf_mwait, perf_flush} !== '0) begin
            tests_failed++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", perf_stall, perf_mwait, perf_flush);
        end
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        do_reset();
        m_rd = 5'd5; m_rf_we = 1'b1; w_rd = 5'd5; w_rf_we = 1'b1; e_rs1 = 5'd5; e_rs2 = 5'd6;
        #1;
        tests_run++;
        if (fwd_a !== (FWD_ON ? 2'b01 : 2'b00)) begin tests_failed++; $display("FAIL fwd_em_a: got %b want %b", fwd_a, FWD_ON ? 2'b01 : 2'b00); end
        tests_run++;
        if (fwd_b !== 2'b00) begin tests_failed++; $display("FAIL fwd_none_b: got %b want 00", fwd_b); end
        @(negedge clk);
        m_rd = 5'd0;
        #1;
        tests_run++;
        if (fwd_a !== (FWD_ON ? 2'b10 : 2'b00)) begin tests_failed++; $display("FAIL fwd_wb_a: got %b want %b", fwd_a, FWD_ON ? 2'b10 : 2'b00); end
        @(negedge clk);
        m_rd = 5'd6; e_rs2 = 5'd6; w_rd = 5'd0;
        #1;
        tests_run++;
        if (fwd_b !== (FWD_ON ? 2'b01 : 2'b00)) begin tests_failed++; $display("FAIL fwd_em_b: got %b want %b", fwd_b, FWD_ON ? 2'b01 : 2'b00); end
    endtask

    task automatic test_load_use();
        do_reset();
        e_rd = 5'd3; e_rf_we = 1'b1; e_mem2rf = 1'b1; d_rs2 = 5'd3; d_use_rs2 = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== C_STALL) begin tests_failed++; $display("FAIL load_use_stall: got %b want %b", ctrl, C_STALL); end
        @(negedge clk);
        e_rd = 5'd0; e_rf_we = 1'b0; e_mem2rf = 1'b0;
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin tests_failed++; $display("FAIL load_use_one_cycle: got %b want %b", ctrl, C_NONE); end
        tests_run++;
        if (perf_stall !== 4'd1) begin tests_failed++; $display("FAIL load_use_count: got %0d want 1", perf_stall); end
        @(negedge clk);
        e_rd = 5'd0; e_rf_we = 1'b1; e_mem2rf = 1'b1; d_rs2 = 5'd0;
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin tests_failed++; $display("FAIL load_use_x0: got %b want %b", ctrl, C_NONE); end
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (perf_stall !== 4'd1) begin tests_failed++; $display("FAIL load_use_x0_count: got %0d want 1", perf_stall); end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        e_rd = 5'd3; e_rf_we = 1'b1; e_mem2rf = 1'b1; d_rs1 = 5'd3; d_use_rs1 = 1'b1; e_br_taken = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== C_FLUSH) begin tests_failed++; $display("FAIL br_over_lu: got %b want %b", ctrl, C_FLUSH); end
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (perf_flush !== 4'd1 || perf_stall !== 4'd0) begin
            tests_failed++; $display("FAIL br_over_lu_counts: got flush=%0d stall=%0d want 1/0", perf_flush, perf_stall);
        end
    endtask

    task automatic test_mem_wait();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            m_mem_req  = 1'b1;
            e_br_taken = (pass == 1);
            for (int i = 0; i < 4; i++) begin
                m_mem_ready = (i == 3);
                #1;
                tests_run++;
                if (ctrl !== C_FREEZE) begin tests_failed++; $display("FAIL mwait_hold_%0d_%0d: got %b want %b", pass, i, ctrl, C_FREEZE); end
                @(negedge clk);
            end
            m_mem_req = 1'b0; m_mem_ready = 1'b0;
            #1;
            tests_run++;
            if (ctrl !== ((pass == 1) ? C_FLUSH : C_NONE)) begin
                tests_failed++; $display("FAIL mwait_release_%0d: got %b want %b", pass, ctrl, (pass == 1) ? C_FLUSH : C_NONE);
            end
            tests_run++;
            if (perf_mwait !== 4'd4) begin tests_failed++; $display("FAIL mwait_count_%0d: got %0d want 4", pass, perf_mwait); end
            @(negedge clk);
            e_br_taken = 1'b0;
            #1;
            tests_run++;
            if (perf_flush !== ((pass == 1) ? 4'd1 : 4'd0)) begin
                tests_failed++; $display("FAIL mwait_flush_count_%0d: got %0d want %0d", pass, perf_flush, pass);
            end
        end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        e_br_taken = 1'b1;
        repeat (20) @(negedge clk);
        e_br_taken = 1'b0;
        #1;
        tests_run++;
        if (perf_flush !== 4'd15) begin tests_failed++; $display("FAIL flush_saturate: got %0d want 15", perf_flush); end
        @(negedge clk);
        m_mem_req = 1'b1;
        @(negedge clk);
        m_rd = 5'd5; m_rf_we = 1'b1; e_rs1 = 5'd5; e_br_taken = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== C_FREEZE) begin tests_failed++; $display("FAIL pre_reset_freeze: got %b want %b", ctrl, C_FREEZE); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ctrl !== C_NONE || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            tests_failed++; $display("FAIL async_reset_outputs: got ctrl=%b fwd=%b/%b want 00000 00/00", ctrl, fwd_a, fwd_b);
        end
        tests_run++;
        if ({perf_stall, perf_mwait, perf_flush} !== '0) begin
            tests_failed++; $display("FAIL async_reset_counters: got %0d/%0d/%0d want 0/0/0", perf_stall, perf_mwait, perf_flush);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        #1;
        tests_run++;
        if (ctrl !== C_NONE) begin tests_failed++; $display("FAIL reset_to_run: got %b want %b", ctrl, C_NONE); end
    endtask

    task automatic test_no_fwd();
        do_reset();
        m_rd = 5'd7; m_rf_we = 1'b1; d_rs1 = 5'd7; d_use_rs1 = 1'b1;
        #1;
        tests_run++;
        if (ctrl !== (FWD_ON ? C_NONE : C_STALL)) begin
            tests_failed++; $display("FAIL raw_m_stall: got %b want %b", ctrl, FWD_ON ? C_NONE : C_STALL);
        end
        tests_run++;
        if (fwd_a !== 2'b00) begin tests_failed++; $display("FAIL raw_m_fwd_a: got %b want 00", fwd_a); end
    endtask

    task automatic test_random();
        logic [4:0] exp_ctrl;
        int         nerr;
        do_reset();
        nerr = 0;
        for (int i = 0; i < 400; i++) begin
            d_rs1 = 5'($urandom_range(0, 3)); d_rs2 = 5'($urandom_range(0, 3));
            e_rs1 = 5'($urandom_range(0, 3)); e_rs2 = 5'($urandom_range(0, 3));
            e_rd  = 5'($urandom_range(0, 3)); m_rd  = 5'($urandom_range(0, 3));
            w_rd  = 5'($urandom_range(0, 3));
            d_use_rs1 = 1'($urandom); d_use_rs2 = 1'($urandom);
            e_rf_we = 1'($urandom); e_mem2rf = 1'($urandom);
            m_rf_we = 1'($urandom); w_rf_we = 1'($urandom);
            e_br_taken  = ($urandom_range(0, 5) == 0);
            m_mem_req   = ($urandom_range(0, 3) == 0);
            m_mem_ready = 1'($urandom);
            #1;
            exp_ctrl = ctrl_of(classify());
            tests_run++;
            if (ctrl !== exp_ctrl || fwd_a !== fwd_of(e_rs1) || fwd_b !== fwd_of(e_rs2) ||
                perf_stall !== CW'(mdl_stall) || perf_mwait !== CW'(mdl_mwait) || perf_flush !== CW'(mdl_flush)) begin
                tests_failed++;
                if (nerr < 10)
                    $display("FAIL random_%0d: got ctrl=%b fwd=%b/%b cnt=%0d/%0d/%0d want ctrl=%b fwd=%b/%b cnt=%0d/%0d/%0d",
                             i, ctrl, fwd_a, fwd_b, perf_stall, perf_mwait, perf_flush,
                             exp_ctrl, fwd_of(e_rs1), fwd_of(e_rs2), mdl_stall, mdl_mwait, mdl_flush);
                nerr++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load_use();
        test_mem_wait();
        test_saturation_and_reset();
        test_no_fwd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
